// File: rtl/pokey_bus_master.sv
// CPU-side bus initiator for POKEY: queues register commands and replays them
// as phi2-aligned bus cycles, returning read data from busDout.
module pokey_bus_master #(
  parameter int unsigned PHI2_HALF = 33,
  parameter int unsigned DEPTH     = 4
) (
  input  logic       clk,
  input  logic       clrBar,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic       cmdRead,
  input  logic [3:0] cmdAddr,
  input  logic [7:0] cmdData,
  output logic       rspValid,
  output logic [7:0] rspData,
  output logic       busy,
  output logic       phi2,
  output logic [3:0] busA,
  output logic [7:0] busDin,
  output logic       busRw,
  output logic       busCs0Bar,
  input  logic [7:0] busDout
);

  localparam int unsigned PW = (PHI2_HALF > 1) ? $clog2(PHI2_HALF) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(PHI2_HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  logic [PW-1:0] phase_cnt;
  logic          wrap_c, rise_tick_c, fall_tick_c;

  cmd_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full_c, empty_c, push_c, pop_c;
  cmd_t          head_c;

  state_t        state_q, state_d;
  logic [3:0]    a_d;
  logic [7:0]    din_d;
  logic          rw_d, cs_d, cap_c;
  logic          rsp_pend;

  assign wrap_c      = (phase_cnt == PH_LAST);
  assign rise_tick_c = wrap_c & ~phi2;
  assign fall_tick_c = wrap_c & phi2;

  assign full_c   = (count == CNT_FULL);
  assign empty_c  = (count == '0);
  assign push_c   = cmdValid & ~full_c;
  assign head_c   = fifo_mem[rd_ptr];
  assign cmdReady = ~full_c;
  assign busy     = ~empty_c | (state_q != IDLE);

  // Free-running phi2 generator: toggles every PHI2_HALF clk.
  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      phase_cnt <= '0;
      phi2      <= 1'b0;
    end else if (wrap_c) begin
      phase_cnt <= '0;
      phi2      <= ~phi2;
    end else begin
      phase_cnt <= phase_cnt + PW'(1);
    end
  end

  // Command storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= '{rd: cmdRead, addr: cmdAddr, data: cmdData};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel in count.
  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Bus-cycle sequencer: loads commands on phi2 fall, captures reads on the next fall.
  always_comb begin
    state_d = state_q;
    a_d     = busA;
    din_d   = busDin;
    rw_d    = busRw;
    cs_d    = busCs0Bar;
    pop_c   = 1'b0;
    cap_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_tick_c && !empty_c) begin
          pop_c   = 1'b1;
          a_d     = head_c.addr;
          din_d   = head_c.data;
          rw_d    = head_c.rd;
          cs_d    = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (rise_tick_c) state_d = DATA;
      end
      DATA: begin
        if (fall_tick_c) begin
          cap_c = busRw;
          if (!empty_c) begin
            pop_c   = 1'b1;
            a_d     = head_c.addr;
            din_d   = head_c.data;
            rw_d    = head_c.rd;
            cs_d    = 1'b0;
            state_d = ADDR;
          end else begin
            cs_d    = 1'b1;
            rw_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered bus drive.
  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      state_q   <= IDLE;
      busA      <= '0;
      busDin    <= '0;
      busRw     <= 1'b1;
      busCs0Bar <= 1'b1;
    end else begin
      state_q   <= state_d;
      busA      <= a_d;
      busDin    <= din_d;
      busRw     <= rw_d;
      busCs0Bar <= cs_d;
    end
  end

  // Read capture at phi2 fall; the valid pulse follows one clk later.
  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      rsp_pend <= 1'b0;
      rspValid <= 1'b0;
      rspData  <= '0;
    end else begin
      rsp_pend <= cap_c;
      rspValid <= rsp_pend;
      if (cap_c) rspData <= busDout;
    end
  end

endmodule

// File: tb/tb_pokey_bus_master.sv
// Bench for pokey_bus_master: two instances (slow and fast phi2) driven by
// directed and random commands, checked against a POKEY register-file model
// and an in-order command/response scoreboard.
module tb_pokey_bus_master;

  localparam int H0  = 33;
  localparam int H1  = 3;
  localparam int LIM = 500;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_cmd_t;

  logic       clk;
  logic       rst_n;
  logic       v [2];
  logic       rd [2];
  logic [3:0] a [2];
  logic [7:0] d [2];
  logic       rdy [2];
  logic       rv [2];
  logic [7:0] rdat [2];
  logic       busy [2];
  logic       phi [2];
  logic [3:0] ba [2];
  logic [7:0] bd [2];
  logic       brw [2];
  logic       bcs [2];
  logic [7:0] dout [2];

  int checks = 0;
  int errors = 0;

  exp_cmd_t   cmdq [2][$];
  logic [7:0] rspq [2][$];
  logic [7:0] sb [2][16];
  logic [7:0] preg [2][16];

  logic       phi_h1 [2], phi_h2 [2], cs_h [2], brw_s [2];
  logic [3:0] ba_s [2];
  logic [7:0] bd_s [2];
  int         run [2], rises [2], rcnt [2], runs [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pokey_bus_master #(.PHI2_HALF(H0), .DEPTH(4)) u_dut0 (
    .clk(clk), .clrBar(rst_n), .cmdValid(v[0]), .cmdReady(rdy[0]),
    .cmdRead(rd[0]), .cmdAddr(a[0]), .cmdData(d[0]), .rspValid(rv[0]),
    .rspData(rdat[0]), .busy(busy[0]), .phi2(phi[0]), .busA(ba[0]),
    .busDin(bd[0]), .busRw(brw[0]), .busCs0Bar(bcs[0]), .busDout(dout[0]));

  pokey_bus_master #(.PHI2_HALF(H1), .DEPTH(4)) u_dut1 (
    .clk(clk), .clrBar(rst_n), .cmdValid(v[1]), .cmdReady(rdy[1]),
    .cmdRead(rd[1]), .cmdAddr(a[1]), .cmdData(d[1]), .rspValid(rv[1]),
    .rspData(rdat[1]), .busy(busy[1]), .phi2(phi[1]), .busA(ba[1]),
    .busDin(bd[1]), .busRw(brw[1]), .busCs0Bar(bcs[1]), .busDout(dout[1]));

  function automatic int hh(input int k);
    return (k == 0) ? H0 : H1;
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
    end
  endtask

  // POKEY model plus bus/response monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        cmdq[k].delete();
        rspq[k].delete();
        for (int r = 0; r < 16; r++) sb[k][r] = preg[k][r];
        run[k] = 0; rises[k] = 0; rcnt[k] = 0;
        phi_h1[k] = 1'b0; phi_h2[k] = 1'b0; cs_h[k] = 1'b1;
        dout[k] = 8'h00;
      end else begin
        if (phi[k] && !phi_h1[k]) begin
          rcnt[k] = 1;
          dout[k] = 8'hxx;
          if (!bcs[k]) begin
            exp_cmd_t e;
            rises[k]++;
            check("stable_addr", k, 32'(ba[k]), 32'(ba_s[k]));
            check("stable_rw", k, 32'(brw[k]), 32'(brw_s[k]));
            check("stable_din", k, 32'(bd[k]), 32'(bd_s[k]));
            check("cmd_expected", k, 32'(cmdq[k].size() != 0), 1);
            if (cmdq[k].size() != 0) begin
              e = cmdq[k].pop_front();
              check("bus_addr", k, 32'(ba[k]), 32'(e.addr));
              check("bus_rw", k, 32'(brw[k]), 32'(e.rd));
              if (!e.rd) check("bus_din", k, 32'(bd[k]), 32'(e.data));
            end
            if (!brw[k]) preg[k][ba[k]] = bd[k];
          end
        end else if (rcnt[k] == 1) begin
          rcnt[k] = 2;
        end else if (rcnt[k] == 2) begin
          rcnt[k] = 0;
          dout[k] = (!bcs[k] && brw[k]) ? preg[k][ba[k]] : 8'hxx;
        end
        if (!bcs[k]) begin
          if (cs_h[k]) begin
            check("cs_fall_on_phi_fall", k, 32'({phi_h1[k], phi[k]}), 32'(2'b10));
            run[k] = 0; rises[k] = 0; runs[k]++;
          end
          run[k]++;
        end else if (!cs_h[k]) begin
          check("cs_low_len", k, 32'(run[k]), 32'(rises[k] * 2 * hh(k)));
        end
        if (rv[k]) begin
          check("rsp_expected", k, 32'(rspq[k].size() != 0), 1);
          check("rsp_timing", k, 32'({phi_h2[k], phi_h1[k], phi[k]}), 32'(3'b100));
          if (rspq[k].size() != 0) check("rsp_data", k, 32'(rdat[k]), 32'(rspq[k].pop_front()));
        end
        ba_s[k] = ba[k]; bd_s[k] = bd[k]; brw_s[k] = brw[k];
        phi_h2[k] = phi_h1[k]; phi_h1[k] = phi[k]; cs_h[k] = bcs[k];
      end
    end
  end

  // Offer one command; returns negedges spent waiting for cmdReady.
  task automatic push(input int k, input logic r, input logic [3:0] ad, input logic [7:0] dt, output int w);
    v[k] = 1'b1; rd[k] = r; a[k] = ad; d[k] = dt; w = 0;
    while (!rdy[k] && w < LIM) begin @(negedge clk); w++; end
    check("push_ready", k, 32'(rdy[k]), 1);
    if (rdy[k]) begin
      cmdq[k].push_back('{rd: r, addr: ad, data: dt});
      if (r) rspq[k].push_back(sb[k][ad]);
      else   sb[k][ad] = dt;
    end
    @(negedge clk);
    v[k] = 1'b0;
  endtask

  task automatic wait_phi(input int k, input logic val);
    int n = 0;
    while (phi[k] !== val && n < LIM) begin @(negedge clk); n++; end
    check("wait_phi", k, 32'(phi[k]), 32'(val));
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    check("wait_idle", k, 32'(busy[k]), 0);
  endtask

  task automatic wait_cs_low(input int k, output int n);
    n = 0;
    while (bcs[k] !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
    check("wait_cs_low", k, 32'(bcs[k]), 0);
  endtask

  initial begin
    int w, n, lows, runs0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; rd[k] = 1'b0; a[k] = '0; d[k] = '0;
      for (int r = 0; r < 16; r++) begin
        preg[k][r] = 8'($urandom);
        sb[k][r]   = preg[k][r];
      end
    end
    preg[0][10] = 8'h3C;
    sb[0][10]   = 8'h3C;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_phi2", k, 32'(phi[k]), 0);
      check("rst_cs", k, 32'(bcs[k]), 1);
      check("rst_rw", k, 32'(brw[k]), 1);
      check("rst_addr", k, 32'(ba[k]), 0);
      check("rst_din", k, 32'(bd[k]), 0);
      check("rst_rspvalid", k, 32'(rv[k]), 0);
      check("rst_rspdata", k, 32'(rdat[k]), 0);
      check("rst_busy", k, 32'(busy[k]), 0);
      check("rst_ready", k, 32'(rdy[k]), 1);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single write A=8 D=0x55.
    push(0, 1'b0, 4'h8, 8'h55, w);
    check("busy_after_push", 0, 32'(busy[0]), 1);
    wait_cs_low(0, n);
    check("wr_addr", 0, 32'(ba[0]), 32'h8);
    check("wr_din", 0, 32'(bd[0]), 32'h55);
    check("wr_rw", 0, 32'(brw[0]), 0);
    check("wr_phi_low", 0, 32'(phi[0]), 0);
    wait_idle(0);

    // Read A=0xA returns 0x3C and holds it across a later write.
    push(0, 1'b1, 4'hA, 8'h00, w);
    wait_idle(0);
    check("rd_data", 0, 32'(rdat[0]), 32'h3C);
    push(0, 1'b0, 4'h1, 8'hA7, w);
    wait_idle(0);
    check("rd_data_held", 0, 32'(rdat[0]), 32'h3C);

    // Five writes on consecutive clk: the fifth waits for the first pop.
    wait_phi(0, 1'b1);
    wait_phi(0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push(0, 1'b0, 4'(i + 2), 8'(8'h10 + i), w);
      if (i < 4) check("burst_wait", 0, 32'(w), 0);
      else begin
        check("burst_wait5", 0, 32'(w), 32'(2 * H0 - 4));
        check("burst_cs_low", 0, 32'(bcs[0]), 0);
      end
    end
    wait_idle(0);

    // Push early in phi1: no bus activity until the next phi2 fall.
    wait_phi(0, 1'b1);
    wait_phi(0, 1'b0);
    repeat (5) @(negedge clk);
    push(0, 1'b0, 4'h7, 8'hC3, w);
    check("late_busy", 0, 32'(busy[0]), 1);
    check("late_cs_high", 0, 32'(bcs[0]), 1);
    wait_cs_low(0, n);
    check("late_latency", 0, 32'(n), 32'(2 * H0 - 6));
    wait_idle(0);

    // Asynchronous reset during the DATA half of a read with a write queued.
    push(0, 1'b1, 4'h3, 8'h00, w);
    push(0, 1'b0, 4'h4, 8'h99, w);
    wait_cs_low(0, n);
    wait_phi(0, 1'b1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_cs", 0, 32'(bcs[0]), 1);
    check("arst_rw", 0, 32'(brw[0]), 1);
    check("arst_addr", 0, 32'(ba[0]), 0);
    check("arst_phi2", 0, 32'(phi[0]), 0);
    check("arst_rspvalid", 0, 32'(rv[0]), 0);
    check("arst_rspdata", 0, 32'(rdat[0]), 0);
    check("arst_ready", 0, 32'(rdy[0]), 1);
    check("arst_busy", 0, 32'(busy[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rel_phi2", 0, 32'(phi[0]), 0);
    lows = 0;
    for (int i = 0; i < 4 * H0; i++) begin
      @(negedge clk);
      if (bcs[0] === 1'b0) lows++;
    end
    check("rel_no_bus", 0, 32'(lows), 0);
    check("rel_busy", 0, 32'(busy[0]), 0);
    check("rel_rspdata", 0, 32'(rdat[0]), 0);

    // Random back-to-back traffic; the first eight alternate read/write.
    for (int k = 1; k >= 0; k--) begin
      runs0 = runs[k];
      for (int i = 0; i < ((k == 1) ? 48 : 12); i++) begin
        logic r;
        r = (i < 8) ? 1'(i % 2) : 1'($urandom_range(0, 1));
        push(k, r, 4'($urandom), 8'($urandom), w);
      end
      wait_idle(k);
      repeat (3) @(negedge clk);
      check("rnd_cmd_drained", k, 32'(cmdq[k].size()), 0);
      check("rnd_rsp_drained", k, 32'(rspq[k].size()), 0);
      check("rnd_single_run", k, 32'(runs[k] - runs0), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
